// File: rtl/riscv_pkg.sv
// riscv_pkg: opcodes, control enums and inter-stage bundles
// shared by every stage of riscv_pipe_core.
package riscv_pkg;

  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_BR  = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  typedef enum logic [2:0] {
    ALU_ADD,
    ALU_SUB,
    ALU_AND,
    ALU_OR,
    ALU_SLT
  } alu_op_e;

  typedef enum logic [1:0] {
    RES_ALU,
    RES_MEM,
    RES_PC4
  } res_sel_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } if_id_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] rs1_val;
    logic [31:0] rs2_val;
    logic [31:0] imm;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    alu_op_e     alu_op;
    logic        alu_src;
    res_sel_e    res_sel;
    logic        reg_we;
    logic        mem_we;
    logic        branch;
    logic        jump;
  } id_ex_t;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc4;
    logic [31:0] alu;
    logic [31:0] st_data;
    logic [4:0]  rd;
    res_sel_e    res_sel;
    logic        reg_we;
    logic        mem_we;
  } ex_mem_t;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc4;
    logic [31:0] alu;
    logic [31:0] ld_data;
    logic [4:0]  rd;
    res_sel_e    res_sel;
    logic        reg_we;
  } mem_wb_t;

endpackage

// File: rtl/riscv_alu.sv
// riscv_alu: add/sub/and/or/signed-slt datapath for the EX stage.
module riscv_alu
  import riscv_pkg::*;
(
  input  alu_op_e     op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] y
);

  always_comb begin
    y = a + b;
    unique case (op)
      ALU_ADD: y = a + b;
      ALU_SUB: y = a - b;
      ALU_AND: y = a & b;
      ALU_OR:  y = a | b;
      ALU_SLT: y = {31'b0, $signed(a) < $signed(b)};
      default: y = a + b;
    endcase
  end

endmodule

// File: rtl/riscv_decode_stage.sv
// riscv_decode_stage: instruction decode, register read and ID/EX register.
module riscv_decode_stage
  import riscv_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        stall,
  input  if_id_t      if_id,
  input  logic        wb_we,
  input  logic [4:0]  wb_rd,
  input  logic [31:0] wb_data,
  output logic [4:0]  rs1_id,
  output logic [4:0]  rs2_id,
  output id_ex_t      id_ex
);

  logic [31:0] ins;
  logic [6:0]  opc;
  logic [2:0]  f3;
  logic [6:0]  f7;
  logic [31:0] rd1;
  logic [31:0] rd2;
  logic [31:0] imm_i;
  logic [31:0] imm_s;
  logic [31:0] imm_b;
  logic [31:0] imm_j;
  id_ex_t      d;

  assign ins    = if_id.instr;
  assign opc    = ins[6:0];
  assign f3     = ins[14:12];
  assign f7     = ins[31:25];
  assign rs1_id = ins[19:15];
  assign rs2_id = ins[24:20];

  assign imm_i = {{20{ins[31]}}, ins[31:20]};
  assign imm_s = {{20{ins[31]}}, ins[31:25], ins[11:7]};
  assign imm_b = {{19{ins[31]}}, ins[31], ins[7],
                  ins[30:25], ins[11:8], 1'b0};
  assign imm_j = {{11{ins[31]}}, ins[31], ins[19:12],
                  ins[20], ins[30:21], 1'b0};

  riscv_reg_file reg_file (
    .clk (clk),
    .we  (wb_we),
    .wa  (wb_rd),
    .wd  (wb_data),
    .ra1 (rs1_id),
    .ra2 (rs2_id),
    .rd1 (rd1),
    .rd2 (rd2)
  );

  // unsupported encodings fall through as NOPs
  always_comb begin
    d         = '0;
    d.pc      = if_id.pc;
    d.instr   = ins;
    d.rs1_val = rd1;
    d.rs2_val = rd2;
    d.rs1     = rs1_id;
    d.rs2     = rs2_id;
    d.rd      = ins[11:7];
    unique case (1'b1)
      (opc == OP_R && f3 == 3'b000 && f7 == 7'h00): begin
        d.reg_we = 1'b1;
      end
      (opc == OP_R && f3 == 3'b000 && f7 == 7'h20): begin
        d.reg_we = 1'b1;
        d.alu_op = ALU_SUB;
      end
      (opc == OP_R && f3 == 3'b111 && f7 == 7'h00): begin
        d.reg_we = 1'b1;
        d.alu_op = ALU_AND;
      end
      (opc == OP_R && f3 == 3'b110 && f7 == 7'h00): begin
        d.reg_we = 1'b1;
        d.alu_op = ALU_OR;
      end
      (opc == OP_R && f3 == 3'b010 && f7 == 7'h00): begin
        d.reg_we = 1'b1;
        d.alu_op = ALU_SLT;
      end
      (opc == OP_I && f3 == 3'b000): begin
        d.reg_we  = 1'b1;
        d.alu_src = 1'b1;
        d.imm     = imm_i;
      end
      (opc == OP_LW && f3 == 3'b010): begin
        d.reg_we  = 1'b1;
        d.alu_src = 1'b1;
        d.imm     = imm_i;
        d.res_sel = RES_MEM;
      end
      (opc == OP_SW && f3 == 3'b010): begin
        d.mem_we  = 1'b1;
        d.alu_src = 1'b1;
        d.imm     = imm_s;
      end
      (opc == OP_BR && f3 == 3'b000): begin
        d.branch = 1'b1;
        d.imm    = imm_b;
      end
      (opc == OP_JAL): begin
        d.jump    = 1'b1;
        d.reg_we  = 1'b1;
        d.res_sel = RES_PC4;
        d.imm     = imm_j;
      end
      default: ;
    endcase
  end

  // a load-use stall leaves a bubble behind the held instruction
  always_ff @(posedge clk) begin
    if (rst || flush || stall) id_ex <= '0;
    else                       id_ex <= d;
  end

endmodule

// File: rtl/riscv_fetch_stage.sv
// riscv_fetch_stage: PC register, instruction fetch and IF/ID register.
module riscv_fetch_stage
  import riscv_pkg::*;
#(
  parameter int          IMEM_DEPTH = 1024,
  parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] target,
  output if_id_t      if_id
);

  localparam int          AW      = $clog2(IMEM_DEPTH);
  localparam logic [31:0] PC_MASK = 32'(IMEM_DEPTH * 4 - 1);

  logic [31:0] pc;
  logic [31:0] instr;

  riscv_imem #(
    .DEPTH (IMEM_DEPTH),
    .AW    (AW)
  ) IMEM (
    .clk   (clk),
    .we    (1'b0),
    .waddr ('0),
    .wdata ('0),
    .raddr (pc[AW+1:2]),
    .rdata (instr)
  );

  // PC wraps within the instruction memory
  always_ff @(posedge clk) begin
    if (rst)           pc <= RESET_PC;
    else if (redirect) pc <= target & PC_MASK;
    else if (!stall)   pc <= (pc + 32'd4) & PC_MASK;
  end

  always_ff @(posedge clk) begin
    if (rst || redirect) begin
      if_id <= '0;
    end else if (!stall) begin
      if_id.pc    <= pc;
      if_id.instr <= instr;
    end
  end

endmodule

// File: rtl/riscv_imem.sv
// riscv_imem: word-addressed instruction store, combinational read.
module riscv_imem #(
  parameter int DEPTH = 1024,
  parameter int AW    = 10
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [31:0]   wdata,
  input  logic [AW-1:0] raddr,
  output logic [31:0]   rdata
);

  logic [31:0] instruction_memory_registers [0:DEPTH-1];

  // write port exists for loaders; the core ties it off
  always_ff @(posedge clk) begin
    if (we) instruction_memory_registers[waddr] <= wdata;
  end

  assign rdata = instruction_memory_registers[raddr];

endmodule

// File: rtl/riscv_reg_file.sv
// riscv_reg_file: 2R1W register file with write-to-read bypass, x0 = 0.
module riscv_reg_file (
  input  logic        clk,
  input  logic        we,
  input  logic [4:0]  wa,
  input  logic [31:0] wd,
  input  logic [4:0]  ra1,
  input  logic [4:0]  ra2,
  output logic [31:0] rd1,
  output logic [31:0] rd2
);

  logic [31:0] reg_file_registers [0:31];

  always_ff @(posedge clk) begin
    if (we && wa != 5'd0) reg_file_registers[wa] <= wd;
  end

  always_comb begin
    rd1 = reg_file_registers[ra1];
    if (ra1 == 5'd0)            rd1 = '0;
    else if (we && wa == ra1)   rd1 = wd;
  end

  always_comb begin
    rd2 = reg_file_registers[ra2];
    if (ra2 == 5'd0)            rd2 = '0;
    else if (we && wa == ra2)   rd2 = wd;
  end

endmodule

// File: rtl/riscv_pipe_core.sv
// riscv_pipe_core: 5-stage RV32I-subset core (IF/ID/EX/MEM/WB).
// Define HAZARD_UNIT_EN for EX forwarding and load-use stalls.
module riscv_pipe_core
  import riscv_pkg::*;
#(
  parameter int          IMEM_DEPTH = 1024,
  parameter int          DMEM_DEPTH = 1024,
  parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
  input  logic clk,
  input  logic rst
);

  localparam int DAW = $clog2(DMEM_DEPTH);

  if_id_t      if_id;
  id_ex_t      id_ex;
  ex_mem_t     ex_mem;
  mem_wb_t     mem_wb;
  logic        stall;
  logic        redirect;
  logic        ld_use;
  logic [31:0] target;
  logic [4:0]  rs1_id;
  logic [4:0]  rs2_id;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic [31:0] alu_b;
  logic [31:0] alu_y;
  logic [31:0] fwd_mem;
  logic [31:0] ld_data;
  logic [31:0] wb_data;
  logic        wb_we;
  logic        unused_bits;

  logic [31:0] data_memory_registers [0:DMEM_DEPTH-1];

  riscv_fetch_stage #(
    .IMEM_DEPTH (IMEM_DEPTH),
    .RESET_PC   (RESET_PC)
  ) Fetch (
    .clk      (clk),
    .rst      (rst),
    .stall    (stall),
    .redirect (redirect),
    .target   (target),
    .if_id    (if_id)
  );

  riscv_decode_stage Decode (
    .clk     (clk),
    .rst     (rst),
    .flush   (redirect),
    .stall   (stall),
    .if_id   (if_id),
    .wb_we   (wb_we),
    .wb_rd   (mem_wb.rd),
    .wb_data (wb_data),
    .rs1_id  (rs1_id),
    .rs2_id  (rs2_id),
    .id_ex   (id_ex)
  );

  assign fwd_mem = (ex_mem.res_sel == RES_PC4) ? ex_mem.pc4 : ex_mem.alu;

`ifdef HAZARD_UNIT_EN
  always_comb begin
    op_a = id_ex.rs1_val;
    if (ex_mem.reg_we && ex_mem.rd != 5'd0 && ex_mem.rd == id_ex.rs1)
      op_a = fwd_mem;
    else if (mem_wb.reg_we && mem_wb.rd != 5'd0 && mem_wb.rd == id_ex.rs1)
      op_a = wb_data;
  end

  always_comb begin
    op_b = id_ex.rs2_val;
    if (ex_mem.reg_we && ex_mem.rd != 5'd0 && ex_mem.rd == id_ex.rs2)
      op_b = fwd_mem;
    else if (mem_wb.reg_we && mem_wb.rd != 5'd0 && mem_wb.rd == id_ex.rs2)
      op_b = wb_data;
  end

  assign ld_use = (id_ex.res_sel == RES_MEM) && (id_ex.rd != 5'd0) &&
                  (id_ex.rd == rs1_id || id_ex.rd == rs2_id);
`else
  assign op_a   = id_ex.rs1_val;
  assign op_b   = id_ex.rs2_val;
  assign ld_use = 1'b0;
`endif

  assign alu_b = id_ex.alu_src ? id_ex.imm : op_b;

  riscv_alu u_alu (
    .op (id_ex.alu_op),
    .a  (op_a),
    .b  (alu_b),
    .y  (alu_y)
  );

  assign redirect = id_ex.jump || (id_ex.branch && op_a == op_b);
  assign target   = id_ex.pc + id_ex.imm;
  assign stall    = ld_use && !redirect;

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_mem <= '0;
    end else begin
      ex_mem.instr   <= id_ex.instr;
      ex_mem.pc4     <= id_ex.pc + 32'd4;
      ex_mem.alu     <= alu_y;
      ex_mem.st_data <= op_b;
      ex_mem.rd      <= id_ex.rd;
      ex_mem.res_sel <= id_ex.res_sel;
      ex_mem.reg_we  <= id_ex.reg_we;
      ex_mem.mem_we  <= id_ex.mem_we;
    end
  end

  assign ld_data = data_memory_registers[ex_mem.alu[DAW+1:2]];

  always_ff @(posedge clk) begin
    if (!rst && ex_mem.mem_we)
      data_memory_registers[ex_mem.alu[DAW+1:2]] <= ex_mem.st_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_wb <= '0;
    end else begin
      mem_wb.instr   <= ex_mem.instr;
      mem_wb.pc4     <= ex_mem.pc4;
      mem_wb.alu     <= ex_mem.alu;
      mem_wb.ld_data <= ld_data;
      mem_wb.rd      <= ex_mem.rd;
      mem_wb.res_sel <= ex_mem.res_sel;
      mem_wb.reg_we  <= ex_mem.reg_we;
    end
  end

  always_comb begin
    wb_data = mem_wb.alu;
    unique case (mem_wb.res_sel)
      RES_MEM: wb_data = mem_wb.ld_data;
      RES_PC4: wb_data = mem_wb.pc4;
      default: wb_data = mem_wb.alu;
    endcase
  end

  assign wb_we = mem_wb.reg_we && !rst;

  assign unused_bits = ^{id_ex.instr, id_ex.rs1, id_ex.rs2, ex_mem.instr,
                         mem_wb.instr, fwd_mem, rs1_id, rs2_id};

endmodule

// File: tb/tb_riscv_pipe_core.sv
// tb_riscv_pipe_core: directed program tests for riscv_pipe_core.
module tb_riscv_pipe_core;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests = 0;
  int   fails = 0;

  logic [31:0] prog [16];

  riscv_pipe_core dut (
    .clk (clk),
    .rst (rst)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] i0;
    logic [31:0] i1;
    logic [31:0] i2;
    logic [4:0]  rd;
    logic [31:0] exp;
  } vec_t;

  vec_t vt [12];

  function automatic logic [31:0] addi(input logic [4:0] rd,
                                       input logic [4:0] rs1,
                                       input logic [11:0] imm);
    return {imm, rs1, 3'b000, rd, 7'b0010011};
  endfunction

  function automatic logic [31:0] rop(input logic [6:0] f7,
                                      input logic [2:0] f3,
                                      input logic [4:0] rd,
                                      input logic [4:0] rs1,
                                      input logic [4:0] rs2);
    return {f7, rs2, rs1, f3, rd, 7'b0110011};
  endfunction

  function automatic vec_t mk(input logic [31:0] i0, input logic [31:0] i1,
                              input logic [31:0] i2, input logic [4:0] rd,
                              input logic [31:0] exp);
    vec_t v;
    v.i0 = i0; v.i1 = i1; v.i2 = i2; v.rd = rd; v.exp = exp;
    return v;
  endfunction

  function automatic logic [31:0] rf(input int i);
    return dut.Decode.reg_file.reg_file_registers[i];
  endfunction

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic clear_prog();
    for (int i = 0; i < 16; i++) prog[i] = 32'h0;
  endtask

  // hold reset, reload memories and registers, then release
  task automatic boot(input bit zero_regs);
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 1024; i++) begin
      dut.Fetch.IMEM.instruction_memory_registers[i] = 32'h0;
      dut.data_memory_registers[i] = 32'h0;
    end
    for (int i = 0; i < 16; i++)
      dut.Fetch.IMEM.instruction_memory_registers[i] = prog[i];
    for (int i = 0; i < 32; i++)
      dut.Decode.reg_file.reg_file_registers[i] =
        (zero_regs || i == 0) ? 32'h0 : (32'hA5A5_0000 | i);
    rst = 1'b0;
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    int bad;
    vt[0]  = mk(32'h00A00093, 32'h0, 32'h0, 5'd1, 32'd10);
    vt[1]  = mk(32'h00A00093, rop(7'h00, 3'b000, 2, 1, 1), 32'h0,
                5'd2, 32'd20);
    vt[2]  = mk(addi(1, 0, 12'hFFD), addi(2, 0, 12'd5),
                rop(7'h20, 3'b000, 3, 2, 1), 5'd3, 32'd8);
    vt[3]  = mk(addi(1, 0, 12'd12), addi(2, 0, 12'd10),
                rop(7'h00, 3'b111, 3, 1, 2), 5'd3, 32'd8);
    vt[4]  = mk(addi(1, 0, 12'd12), addi(2, 0, 12'd10),
                rop(7'h00, 3'b110, 3, 1, 2), 5'd3, 32'd14);
    vt[5]  = mk(addi(1, 0, 12'hFFD), addi(2, 0, 12'd5),
                rop(7'h00, 3'b010, 3, 1, 2), 5'd3, 32'd1);
    vt[6]  = mk(addi(1, 0, 12'hFFD), addi(2, 0, 12'd5),
                rop(7'h00, 3'b010, 3, 2, 1), 5'd3, 32'd0);
    vt[7]  = mk(addi(0, 0, 12'd9), 32'h0, 32'h0, 5'd0, 32'd0);
    vt[8]  = mk(addi(1, 0, 12'hFFF), 32'h0, 32'h0, 5'd1, 32'hFFFF_FFFF);
    vt[9]  = mk(addi(1, 0, 12'h7FF), addi(2, 0, 12'h800),
                rop(7'h00, 3'b000, 3, 1, 2), 5'd3, 32'hFFFF_FFFF);
    vt[10] = mk(addi(1, 0, 12'd1), rop(7'h00, 3'b100, 5, 1, 1), 32'h0,
                5'd5, 32'hA5A5_0005);
    vt[11] = mk(addi(1, 0, 12'd3), 32'hFFFF_FFFF, 32'h0,
                5'd31, 32'hA5A5_001F);

    for (int k = 0; k < 12; k++) begin
      clear_prog();
      prog[0] = vt[k].i0;
      prog[4] = vt[k].i1;
      prog[8] = vt[k].i2;
      boot(1'b0);
      cycles(16);
      check($sformatf("vec%0d_x%0d", k, vt[k].rd), rf(int'(vt[k].rd)),
            vt[k].exp);
      if (k == 0) begin
        bad = 0;
        for (int r = 2; r < 32; r++)
          if (rf(r) !== (32'hA5A5_0000 | r)) bad++;
        check("others_unchanged", 32'(bad), 32'd0);
      end
    end

    // first instruction commits at the end of its 5th cycle
    clear_prog();
    prog[0] = 32'h00A00093;
    boot(1'b0);
    check("reset_pc", dut.Fetch.pc, 32'h0);
    cycles(4);
    check("lat_before", rf(1), 32'hA5A5_0001);
    cycles(1);
    check("lat_at5", rf(1), 32'd10);

    // store then load through memory
    clear_prog();
    prog[0]  = addi(1, 0, 12'd7);
    prog[4]  = 32'h00102423;
    prog[8]  = 32'h00802183;
    prog[12] = rop(7'h00, 3'b000, 4, 3, 3);
    boot(1'b0);
    cycles(20);
    check("sw_dmem2", dut.data_memory_registers[2], 32'd7);
    check("lw_x3", rf(3), 32'd7);
    check("ld_add_x4", rf(4), 32'd14);
    check("dmem3_clean", dut.data_memory_registers[3], 32'h0);

    // taken BEQ flushes the shadow instruction
    clear_prog();
    prog[0] = addi(1, 0, 12'd5);
    prog[1] = addi(2, 0, 12'd5);
    prog[5] = 32'h00208463;
    prog[6] = addi(3, 0, 12'd1);
    prog[7] = addi(4, 0, 12'd2);
    boot(1'b1);
    cycles(20);
    check("beq_taken_x3", rf(3), 32'd0);
    check("beq_taken_x4", rf(4), 32'd2);

    prog[1] = addi(2, 0, 12'd6);
    boot(1'b1);
    cycles(20);
    check("beq_nt_x3", rf(3), 32'd1);
    check("beq_nt_x4", rf(4), 32'd2);

    // JAL links PC+4 and skips the next word
    clear_prog();
    prog[0] = 32'h008002EF;
    prog[1] = addi(6, 0, 12'd1);
    prog[2] = addi(7, 0, 12'd3);
    boot(1'b1);
    cycles(12);
    check("jal_x5", rf(5), 32'd4);
    check("jal_skip_x6", rf(6), 32'd0);
    check("jal_tgt_x7", rf(7), 32'd3);

    // reset mid-program
    clear_prog();
    prog[0] = addi(1, 0, 12'd10);
    prog[4] = addi(2, 0, 12'd20);
    prog[5] = 32'h00102223;
    boot(1'b0);
    dut.data_memory_registers[1] = 32'h1234_5678;
    cycles(6);
    rst = 1'b1;
    cycles(4);
    check("rst_pc", dut.Fetch.pc, 32'h0);
    check("rst_ifid", dut.Fetch.if_id.instr, 32'h0);
    check("rst_idex", dut.id_ex.instr, 32'h0);
    check("rst_exmem", dut.ex_mem.instr, 32'h0);
    check("rst_memwb", dut.mem_wb.instr, 32'h0);
    check("rst_kept_x1", rf(1), 32'd10);
    check("rst_squash_x2", rf(2), 32'hA5A5_0002);
    check("rst_squash_sw", dut.data_memory_registers[1], 32'h1234_5678);
    check("rst_keep_x9", rf(9), 32'hA5A5_0009);
    rst = 1'b0;
    cycles(16);
    check("rerun_x2", rf(2), 32'd20);
    check("rerun_sw", dut.data_memory_registers[1], 32'd10);

    // PC wraps after the last instruction word
    clear_prog();
    prog[0] = addi(1, 1, 12'd1);
    boot(1'b1);
    cycles(1025);
    check("wrap_pc", dut.Fetch.pc, 32'd4);
    cycles(5);
    check("wrap_x1", rf(1), 32'd2);

`ifdef HAZARD_UNIT_EN
    clear_prog();
    prog[0] = 32'h00A00093;
    prog[1] = rop(7'h00, 3'b000, 2, 1, 1);
    boot(1'b0);
    cycles(10);
    check("fwd_x2", rf(2), 32'd20);

    clear_prog();
    prog[0] = addi(1, 0, 12'd7);
    prog[1] = 32'h00102423;
    prog[2] = 32'h00802183;
    prog[3] = rop(7'h00, 3'b000, 4, 3, 3);
    boot(1'b0);
    cycles(8);
    check("stall_x4_early", rf(4), 32'hA5A5_0004);
    cycles(1);
    check("stall_x4", rf(4), 32'd14);
    check("stall_dmem2", dut.data_memory_registers[2], 32'd7);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
